// File: rtl/uart_echo_fifo.sv
// UART receiver feeding a small FIFO that a transmitter drains, echoing each
// good word back out with a configurable frame format and error/occupancy status.
module uart_echo_fifo #(
    parameter int CLKS_PER_BIT = 280,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          rx_i,
    output logic                          tx_o,
    input  logic                          tx_pause_i,
    output logic                          frame_err_o,
    output logic                          parity_err_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic             HAS_PAR   = (PARITY_MODE != 0);
    localparam logic             PAR_ODD   = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_e;
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    // ---------------- synchroniser ----------------
    logic rx_meta_q, rx_s_q, rx_prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // ---------------- receiver ----------------
    rx_state_e              rx_state_q, rx_state_d;
    logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]       rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic                   rx_par_q, rx_par_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   rx_tick, par_bad, push;

    assign rx_tick = (rx_cnt_q == BIT_END);
    assign par_bad = ((^rx_shift_q) ^ rx_par_q) != PAR_ODD;

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_par_d     = rx_par_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        push         = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s_q) begin
                    rx_state_d = RX_START;
                    rx_bit_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_BIT) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == LAST_DATA) rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
                    else                       rx_bit_d   = rx_bit_q + BIT_W'(1);
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_PARITY: begin
                if (rx_tick) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = rx_s_q;
                    rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    rx_cnt_d = '0;
                    // A low stop bit outranks a parity mismatch.
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
                        rx_state_d  = RX_WAIT_HIGH;
                    end else if (HAS_PAR && par_bad) begin
                        parity_err_d = 1'b1;
                        rx_state_d   = RX_IDLE;
                    end else begin
                        push       = 1'b1;
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_WAIT_HIGH: begin
                rx_cnt_d = '0;
                if (rx_s_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_q     <= rx_par_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]       count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 pop, full, push_acc;
    logic [DATA_BITS-1:0] rd_data;

    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign full       = (count_q == FULL_CNT);
    assign push_acc   = push && (!full || pop);
    assign overflow_d = push && full && !pop;
    assign count_d    = count_q + (PTR_W + 1)'(push_acc) - (PTR_W + 1)'(pop);
    assign rd_data    = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push_acc) mem_q[wr_ptr_q] <= rx_shift_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_acc) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)      rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // ---------------- transmitter ----------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;
    logic                 tx_tick;

    assign tx_tick = (tx_cnt_q == BIT_END);

    // tx_d is the level of the current state's bit; the register lags it by one
    // edge, which gives the one-cycle gap between the pop and the start bit.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = 1'b1;
        pop        = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_bit_d = '0;
                if (count_q != '0 && !tx_pause_i) begin
                    pop        = 1'b1;
                    tx_shift_d = rd_data;
                    tx_par_d   = (^rd_data) ^ PAR_ODD;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                tx_d = 1'b0;
                if (tx_tick) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_DATA: begin
                tx_d = tx_shift_q[0];
                if (tx_tick) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                    if (tx_bit_q == LAST_DATA) begin
                        tx_bit_d   = '0;
                        tx_state_d = HAS_PAR ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_W'(1);
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_PARITY: begin
                tx_d = tx_par_q;
                if (tx_tick) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == LAST_STOP) begin
                        tx_bit_d   = '0;
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_W'(1);
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    assign tx_o         = tx_q;
    assign frame_err_o  = frame_err_q;
    assign parity_err_o = parity_err_q;
    assign overflow_o   = overflow_q;
    assign fifo_count_o = count_q;
endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
Parametrised successor to the single-byte UART echo block. It receives serial frames on rx_i, checks them for framing and parity errors, and buffers good data words in a FIFO of depth FIFO_DEPTH. A transmitter drains the FIFO and re-sends each word on tx_o. It adds a configurable frame format, a TX pause input, and error and occupancy status for the board-level ALU/UART top.

Parameters:
CLKS_PER_BIT, 280, clock cycles per bit period (280 = 115200 baud at 32.256 MHz); legal range 8 or more.
DATA_BITS, 8, data bits per frame, 5..9, sent and received LSB first.
PARITY_MODE, 0, parity mode: 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits on TX, 1 or 2; RX checks only the first stop bit.
FIFO_DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.

Ports:
clk_i  input  1  system clock; the block has one clock.
rst_ni  input  1  synchronous, active-low reset.
rx_i  input  1  asynchronous serial input; idles high.
tx_o  output  1  serial output; idles high.
tx_pause_i  input  1  when 1, TX does not start a new frame; a frame already in progress completes.
frame_err_o  output  1  one-cycle pulse when a stop bit is sampled low.
parity_err_o  output  1  one-cycle pulse on a parity mismatch.
overflow_o  output  1  one-cycle pulse when a good word is dropped because the FIFO is full.
fifo_count_o  output  $clog2(FIFO_DEPTH)+1  number of words currently in the FIFO.

Behaviour:
- Reset: the synchronous reset sampled low forces the following on the next edge:
  - tx_o = 1; frame_err_o, parity_err_o, overflow_o = 0; fifo_count_o = 0.
  - FIFO is flushed; RX and TX go to IDLE.
  - A frame in progress is abandoned, including mid-frame; tx_o goes high on that same edge.
- RX input: rx_i passes through a 2-flop synchroniser to give rx_s. All RX timing below is measured on rx_s.
- RX state machine: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: a high-to-low transition on rx_s moves to START and clears the bit counter.
  - START: sample rx_s at count CLKS_PER_BIT/2 (integer divide).
    - If rx_s is high, this is a false start: return to IDLE with no pulse.
    - If low, go to DATA.
  - DATA: sample one bit every CLKS_PER_BIT cycles, DATA_BITS samples in total, shifting into an LSB-first shift register.
  - PARITY: present only when PARITY_MODE != 0. Sample one bit. Even parity means the XOR of the data and parity bits is 0; odd parity means it is 1.
  - STOP: sample one bit.
    - Low: pulse frame_err_o, drop the word, go to WAIT_HIGH. A frame error takes precedence; parity_err_o is not pulsed.
    - High with a parity mismatch: pulse parity_err_o, drop the word, go to IDLE.
    - Otherwise: issue the FIFO push on that edge and go to IDLE.
  - WAIT_HIGH: stay until rx_s = 1, so a break condition produces exactly one frame_err_o pulse.
- FIFO:
  - A push while full drops the word and pulses overflow_o. The exception is a pop on the same edge, in which case the push is accepted and the count is unchanged.
  - A simultaneous push and pop when empty is not possible, because a pop requires a non-empty FIFO at the start of the cycle.
  - fifo_count_o is registered and updates on the push/pop edge.
- TX state machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the FIFO is non-empty and tx_pause_i = 0, pop on this edge and latch the word.
  - On the next edge tx_o goes low (start of START).
  - Latency: with TX idle and the FIFO empty, tx_o falls exactly 2 edges after the push edge.
  - Every bit, including each stop bit, lasts exactly CLKS_PER_BIT cycles.
  - Frame order: start(0), DATA_BITS data bits LSB first, the parity bit (if enabled), then STOP_BITS ones.
  - After the last stop bit, return to IDLE. Back-to-back frames are allowed, with no extra idle cycles beyond the 1-cycle pop.
- Counters: the bit-period counter width is $clog2(CLKS_PER_BIT). The bit counter width is $clog2(DATA_BITS+1). Neither counter wraps past its terminal count.
- Error pulses: all error pulses are exactly 1 cycle and come from registers.

Test Plan:
- Default parameters, send 0x41 at 280 cycles per bit → tx_o echoes frame 0x41; fifo_count_o goes 0→1→0; no error pulses.
- rx_i low for 100 cycles then high → false start; no push, tx_o stays 1, fifo_count_o = 0.
- Send 0x55 with the stop bit forced low, then hold rx_i low for 3000 cycles → exactly one frame_err_o pulse; no echo; the next good byte 0x3C echoes correctly.
- PARITY_MODE=1: send 0xA5 with parity 0 → echo 0xA5 with parity 0. Then send 0xA5 with parity 1 → one parity_err_o pulse, no echo.
- FIFO_DEPTH=4, tx_pause_i=1: send 0x01..0x05 → fifo_count_o = 4, one overflow_o pulse on byte 0x05. Release the pause → tx_o emits 0x01,0x02,0x03,0x04 back to back.
- Assert the synchronous reset mid-way through the TX data bits with 2 words buffered → tx_o = 1 and fifo_count_o = 0 after 1 edge. After release, a new byte 0x7E echoes normally.
